// File: rtl/adder_seq_pkg.sv
// Shared types and defaults for the adder operand sequencer.
package adder_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT   = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int DEF_CNT_W       = 8;

  // A zero-cycle wait still needs a one-bit counter so the port widths stay legal.
  function automatic int wait_cnt_w(input int wait_cycles);
    return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/adder_operand_sequencer.sv
// Host-to-adder operand sequencer: takes an (A,B) pair, beats A then B onto the
// adder bus, waits the adder latency, captures the result and hands it back.
module adder_operand_sequencer
  import adder_seq_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] adder_a,
  output logic             adder_ena,
  input  logic [WIDTH-1:0] adder_z,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [CNT_W-1:0] op_count
);

  localparam int WC_W = wait_cnt_w(WAIT_CYCLES);
  localparam logic [WC_W-1:0] WC_LOAD = WC_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [WC_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] adder_a_q, adder_a_d;
  logic             adder_ena_q, adder_ena_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             accept;
  logic             capture;
  logic             deliver;

  assign accept  = (state_q == IDLE) && in_valid;
  // The result is sampled on the edge that leaves the wait window (or SEND_B when there is none).
  assign capture = ((state_q == SEND_B) && (WAIT_CYCLES == 0)) ||
                   ((state_q == WAIT) && (cnt_q == '0));
  assign deliver = (state_q == HOLD) && res_valid_q && res_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND_A;
          b_d     = in_b;
        end
      end
      SEND_A: state_d = SEND_B;
      SEND_B: begin
        if (WAIT_CYCLES == 0) begin
          state_d = HOLD;
        end else begin
          state_d = WAIT;
          cnt_d   = WC_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - WC_W'(1);
      end
      HOLD: begin
        if (deliver) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so each is computed for the state being entered.
  always_comb begin
    adder_a_d   = '0;
    adder_ena_d = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    op_count_d  = op_count_q;
    if (accept) begin
      adder_a_d   = in_a;
      adder_ena_d = 1'b1;
    end else if (state_q == SEND_A) begin
      adder_a_d   = b_q;
      adder_ena_d = 1'b1;
    end
    if (capture) begin
      res_valid_d = 1'b1;
      res_data_d  = adder_z;
    end
    if (deliver) begin
      res_valid_d = 1'b0;
      op_count_d  = op_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adder_a_q   <= '0;
      adder_ena_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      op_count_q  <= '0;
    end else begin
      adder_a_q   <= adder_a_d;
      adder_ena_q <= adder_ena_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      op_count_q  <= op_count_d;
    end
  end

  always_ff @(posedge clk) begin
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign adder_a   = adder_a_q;
  assign adder_ena = adder_ena_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Bench for adder_operand_sequencer: registered adder model plus a transaction-level
// reference that predicts bus beats, result timing and counts from the accept edge.
module tb_adder_operand_sequencer;

  localparam int WC  = 2;
  localparam int CAP = 2 + WC;  // result visible after this many edges past the accept edge

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic       in_ready, adder_ena, res_valid;
  logic [7:0] adder_a, res_data, op_count;
  logic [7:0] adder_z;
  logic       w_in_ready, w_adder_ena, w_res_valid;
  logic [7:0] w_adder_a, w_res_data;
  logic [1:0] w_op_count;

  always #5 clk = ~clk;

  adder_operand_sequencer #(.WIDTH(8), .WAIT_CYCLES(WC), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .adder_a(adder_a), .adder_ena(adder_ena),
    .adder_z(adder_z), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .op_count(op_count)
  );

  adder_operand_sequencer #(.WIDTH(8), .WAIT_CYCLES(WC), .CNT_W(2)) dut_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_b(in_b), .adder_a(w_adder_a), .adder_ena(w_adder_ena),
    .adder_z(adder_z), .res_valid(w_res_valid), .res_ready(res_ready),
    .res_data(w_res_data), .op_count(w_op_count)
  );

  // Adder core model: first enabled beat is A, second is B, z registered.
  logic [7:0] sa;
  logic       beat;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat    <= 1'b0;
      sa      <= '0;
      adder_z <= '0;
    end else if (adder_ena) begin
      if (!beat) begin
        sa   <= adder_a;
        beat <= 1'b1;
      end else begin
        adder_z <= sa + adder_a;
        beat    <= 1'b0;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit busy = 0;
  int cyc = 0;
  int ops = 0;
  int cycle = 0;
  logic [7:0] ea = '0, eb = '0, ez = '0, hs_data = '0;
  int acc_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] exp_a;
    bit exp_rv;
    exp_a  = !busy ? 8'h00 : (cyc == 0) ? ea : (cyc == 1) ? eb : 8'h00;
    exp_rv = busy && (cyc >= CAP);
    check("in_ready", in_ready, !busy);
    check("adder_ena", adder_ena, busy && (cyc < 2));
    check("adder_a", adder_a, exp_a);
    check("res_valid", res_valid, exp_rv);
    if (exp_rv) check("res_data", res_data, ez);
    check("op_count", op_count, ops % 256);
    check("wrap_op_count", w_op_count, ops % 4);
    check("wrap_res_valid", w_res_valid, exp_rv);
  endtask

  task automatic step(output bit acc);
    bit rhs;
    acc = in_valid && !busy;
    rhs = busy && (cyc >= CAP) && res_ready;
    if (rhs) hs_data = res_data;
    @(posedge clk);
    #1;
    cycle++;
    if (rhs) begin
      busy = 0;
      ops++;
    end
    if (busy) cyc++;
    if (acc) begin
      busy = 1;
      cyc  = 0;
      ea   = in_a;
      eb   = in_b;
      ez   = ea + eb;
      acc_cyc.push_back(cycle);
    end
    check_outputs();
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    bit acc;
    in_a = a; in_b = b; in_valid = 1'b1; res_ready = 1'b1;
    step(acc);
    in_valid = 1'b0;
    in_a = 8'($urandom); in_b = 8'($urandom);
    repeat (CAP + 1) step(acc);
  endtask

  initial begin
    bit acc;
    int got_ops;
    int wrap_exp[5] = '{1, 2, 3, 0, 1};

    #1;
    check("rst_ena", adder_ena, 0);
    check("rst_adder_a", adder_a, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_op_count", op_count, 0);
    check("rst_in_ready", in_ready, 1);
    #11 reset = 1'b0;

    run_op(8'h12, 8'h34);
    check("single_res", hs_data, 8'h46);
    check("single_count", op_count, 1);
    run_op(8'hF0, 8'h20);
    check("overflow_res", hs_data, 8'h10);

    // Backpressure: result held while new pairs are offered and refused.
    in_a = 8'h12; in_b = 8'h34; in_valid = 1'b1; res_ready = 1'b0;
    step(acc);
    for (int i = 0; i < 20 && cyc < CAP; i++) step(acc);
    check("bp_reached_hold", res_valid, 1);
    for (int i = 0; i < 10; i++) begin
      in_a = 8'($urandom); in_b = 8'($urandom);
      step(acc);
    end
    check("bp_res_held", res_data, 8'h46);
    in_valid = 1'b0; res_ready = 1'b1;
    got_ops = ops;
    step(acc);
    check("bp_accepted_once", ops - got_ops, 1);
    check("bp_ready_after", in_ready, 1);
    step(acc);
    check("bp_no_dup", res_valid, 0);

    // Back-to-back with both handshakes held high.
    acc_cyc.delete();
    got_ops = ops;
    in_a = 8'($urandom); in_b = 8'($urandom); in_valid = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 40 && acc_cyc.size() < 4; i++) begin
      step(acc);
      if (acc) begin in_a = 8'($urandom); in_b = 8'($urandom); end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && busy; i++) step(acc);
    check("b2b_ops", ops - got_ops, 4);
    check("b2b_accepts", acc_cyc.size(), 4);
    for (int i = 1; i < acc_cyc.size(); i++) check("b2b_period", acc_cyc[i] - acc_cyc[i-1], 4 + WC);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      res_ready = ($urandom_range(0, 3) != 0);
      in_a = 8'($urandom); in_b = 8'($urandom);
      step(acc);
    end
    in_valid = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 20 && busy; i++) step(acc);
    check("rand_drained", busy, 0);

    // Reset while waiting on the adder.
    in_a = 8'h55; in_b = 8'h22; in_valid = 1'b1; res_ready = 1'b1;
    step(acc);
    in_valid = 1'b0;
    step(acc);
    step(acc);
    #2 reset = 1'b1;
    #1;
    busy = 0; ops = 0;
    check("mid_rst_ena", adder_ena, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_op_count", op_count, 0);
    check("mid_rst_wrap_count", w_op_count, 0);
    #10 reset = 1'b0;
    repeat (8) step(acc);

    // Counter wrap on the narrow-counter instance.
    for (int k = 0; k < 5; k++) begin
      run_op(8'($urandom), 8'($urandom));
      check("wrap_seq", w_op_count, wrap_exp[k]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
